// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// The arbiter FSM uses a 3-bit state encoding.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    STATE_IDLE   = 3'd0,
    STATE_BUSY_I = 3'd1,
    STATE_BUSY_D = 3'd2,
    STATE_RESP_I = 3'd3,
    STATE_RESP_D = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between the fetch port and the data port.
// Data has priority; a starvation counter hands the grant to fetch after STARVE_MAX data wins.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall_if,
  output logic              stall_d,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t        r_state, w_state_next;
  logic              r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_next;
  logic [DATA_W-1:0] r_d_rdata, w_d_rdata_next;
  logic [CNT_W-1:0]  r_starve_cnt, w_starve_cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= STATE_IDLE;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_if_rdata   <= w_if_rdata_next;
      r_d_rdata    <= w_d_rdata_next;
      r_starve_cnt <= w_starve_cnt_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_mem_we_next     = r_mem_we;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_if_rdata_next   = r_if_rdata;
    w_d_rdata_next    = r_d_rdata;
    w_starve_cnt_next = r_starve_cnt;
    case (r_state)
      STATE_IDLE: begin
        // Data wins unless fetch is waiting and has already lost STARVE_MAX times.
        if (d_req && ((r_starve_cnt < CNT_MAX) || !if_req)) begin
          w_mem_addr_next  = d_addr;
          w_mem_wdata_next = d_wdata;
          w_mem_we_next    = d_we;
          w_state_next     = STATE_BUSY_D;
          if (if_req && (r_starve_cnt < CNT_MAX)) begin
            w_starve_cnt_next = r_starve_cnt + 1'b1;
          end
        end else if (if_req) begin
          w_mem_addr_next   = if_addr;
          w_mem_we_next     = 1'b0;
          w_state_next      = STATE_BUSY_I;
          w_starve_cnt_next = '0;
        end
        if (!if_req) begin
          w_starve_cnt_next = '0;
        end
      end
      STATE_BUSY_I: begin
        if (mem_ready) begin
          w_if_rdata_next = mem_rdata;
          w_state_next    = STATE_RESP_I;
        end
      end
      STATE_BUSY_D: begin
        if (mem_ready) begin
          if (!r_mem_we) begin
            w_d_rdata_next = mem_rdata;
          end
          w_state_next = STATE_RESP_D;
        end
      end
      STATE_RESP_I: w_state_next = STATE_IDLE;
      STATE_RESP_D: w_state_next = STATE_IDLE;
      default:      w_state_next = STATE_IDLE;
    endcase
  end

  assign mem_req   = (r_state == STATE_BUSY_I) || (r_state == STATE_BUSY_D);
  assign mem_we    = r_mem_we & mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_valid  = (r_state == STATE_RESP_I);
  assign d_valid   = (r_state == STATE_RESP_D);
  assign stall_if  = if_req & ~if_valid;
  assign stall_d   = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: reset, fetch, load with wait states, store,
// contention/starvation, idle mem_ready and reset during an access.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              stall_if;
  logic              stall_d;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .stall_if(stall_if), .stall_d(stall_d),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    step(); step();
    n_checks++;
    if ({mem_req, mem_we, if_valid, d_valid, stall_if, stall_d} !== 6'b0) begin
      $display("FAIL reset_ctrl: got %b expected 000000",
               {mem_req, mem_we, if_valid, d_valid, stall_if, stall_d});
      n_fail++;
    end
    n_checks++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
      $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h d_rdata=%h expected all 0",
               mem_addr, mem_wdata, if_rdata, d_rdata);
      n_fail++;
    end
    reset = 1'b0;
    step();
    $display("reset: outputs idle after reset");
  endtask

  task automatic test_fetch();
    // cycle 0
    if_req = 1'b1; if_addr = 32'h0040_0000; mem_ready = 1'b1; mem_rdata = 32'h2008_0005;
    #1;
    n_checks++;
    if (stall_if !== 1'b1 || mem_req !== 1'b0) begin
      $display("FAIL fetch_c0: stall_if=%b mem_req=%b expected 1 0", stall_if, mem_req);
      n_fail++;
    end
    step(); // cycle 1
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0040_0000 || stall_if !== 1'b1) begin
      $display("FAIL fetch_c1: mem_req=%b mem_we=%b mem_addr=%h stall_if=%b expected 1 0 00400000 1",
               mem_req, mem_we, mem_addr, stall_if);
      n_fail++;
    end
    step(); // cycle 2
    n_checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h2008_0005 || stall_if !== 1'b0 || mem_req !== 1'b0) begin
      $display("FAIL fetch_c2: if_valid=%b if_rdata=%h stall_if=%b mem_req=%b expected 1 20080005 0 0",
               if_valid, if_rdata, stall_if, mem_req);
      n_fail++;
    end
    step(); // cycle 3
    if_req = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || d_valid !== 1'b0) begin
      $display("FAIL fetch_pulse: if_valid=%b d_valid=%b expected 0 0", if_valid, d_valid);
      n_fail++;
    end
    $display("fetch: addr=%h rdata=%h", 32'h0040_0000, if_rdata);
  endtask

  task automatic test_load_wait();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_0010; mem_ready = 1'b0; mem_rdata = 32'h0;
    for (int c = 1; c <= 3; c++) begin
      step();
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h1000_0010 || d_valid !== 1'b0 || stall_d !== 1'b1) begin
        $display("FAIL load_busy%0d: mem_req=%b mem_addr=%h d_valid=%b stall_d=%b expected 1 10000010 0 1",
                 c, mem_req, mem_addr, d_valid, stall_d);
        n_fail++;
      end
    end
    step(); // cycle 4: memory completes
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step(); // cycle 5
    n_checks++;
    if (d_valid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF || stall_d !== 1'b0) begin
      $display("FAIL load_resp: d_valid=%b d_rdata=%h stall_d=%b expected 1 deadbeef 0",
               d_valid, d_rdata, stall_d);
      n_fail++;
    end
    step();
    d_req = 1'b0; mem_ready = 1'b0;
    n_checks++;
    if (d_valid !== 1'b0) begin
      $display("FAIL load_pulse: d_valid=%b expected 0", d_valid);
      n_fail++;
    end
    $display("load: addr=%h rdata=%h", 32'h1000_0010, d_rdata);
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0020; d_wdata = 32'h0000_00AB;
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    step(); // cycle 1
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h0000_00AB || mem_addr !== 32'h1000_0020) begin
      $display("FAIL store_busy: mem_req=%b mem_we=%b mem_wdata=%h mem_addr=%h expected 1 1 000000ab 10000020",
               mem_req, mem_we, mem_wdata, mem_addr);
      n_fail++;
    end
    step(); // cycle 2
    n_checks++;
    if (d_valid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF || mem_we !== 1'b0) begin
      $display("FAIL store_resp: d_valid=%b d_rdata=%h mem_we=%b expected 1 deadbeef 0",
               d_valid, d_rdata, mem_we);
      n_fail++;
    end
    step();
    d_req = 1'b0; d_we = 1'b0;
    $display("store: addr=%h wdata=%h", 32'h1000_0020, 32'h0000_00AB);
  endtask

  task automatic test_contention();
    logic is_data [6];
    is_data = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    if_req = 1'b1; if_addr = 32'h0040_0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_0100;
    mem_ready = 1'b1; mem_rdata = 32'hC0DE_0000;
    for (int g = 0; g < 6; g++) begin
      step(); // BUSY
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== (is_data[g] ? 32'h1000_0100 : 32'h0040_0100)) begin
        $display("FAIL contention_grant%0d: mem_req=%b mem_addr=%h expected 1 %h", g, mem_req, mem_addr,
                 is_data[g] ? 32'h1000_0100 : 32'h0040_0100);
        n_fail++;
      end
      step(); // RESP
      n_checks++;
      if (d_valid !== is_data[g] || if_valid !== !is_data[g]) begin
        $display("FAIL contention_resp%0d: d_valid=%b if_valid=%b expected %b %b", g, d_valid, if_valid,
                 is_data[g], !is_data[g]);
        n_fail++;
      end
      $display("contention: grant %0d to %s", g, is_data[g] ? "data" : "fetch");
      step(); // back in IDLE
    end
    if_req = 1'b0; d_req = 1'b0;
    n_checks++;
    if (if_rdata !== 32'hC0DE_0000) begin
      $display("FAIL contention_if_rdata: got %h expected c0de0000", if_rdata);
      n_fail++;
    end
  endtask

  task automatic test_idle_ready();
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (mem_req !== 1'b0 || if_valid !== 1'b0 || d_valid !== 1'b0 ||
          if_rdata !== 32'hC0DE_0000 || d_rdata !== 32'hC0DE_0000) begin
        $display("FAIL idle_ready%0d: mem_req=%b if_valid=%b d_valid=%b if_rdata=%h d_rdata=%h expected 0 0 0 c0de0000 c0de0000",
                 c, mem_req, if_valid, d_valid, if_rdata, d_rdata);
        n_fail++;
      end
    end
    mem_ready = 1'b0;
    $display("idle_ready: mem_ready ignored while idle");
  endtask

  task automatic test_reset_mid_access();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0030; d_wdata = 32'h0000_0055; mem_ready = 1'b0;
    step(); // BUSY_D
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      $display("FAIL midreset_busy: mem_req=%b mem_we=%b expected 1 1", mem_req, mem_we);
      n_fail++;
    end
    reset = 1'b1; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b1;
    step();
    n_checks++;
    if (mem_req !== 1'b0 || d_valid !== 1'b0) begin
      $display("FAIL midreset_drop: mem_req=%b d_valid=%b expected 0 0", mem_req, d_valid);
      n_fail++;
    end
    step();
    n_checks++;
    if ({mem_req, mem_we, if_valid, d_valid} !== 4'b0 ||
        {mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
      $display("FAIL midreset_state: ctrl=%b addr=%h wdata=%h if_rdata=%h d_rdata=%h expected all 0",
               {mem_req, mem_we, if_valid, d_valid}, mem_addr, mem_wdata, if_rdata, d_rdata);
      n_fail++;
    end
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (d_valid !== 1'b0 || mem_req !== 1'b0) begin
        $display("FAIL midreset_after%0d: d_valid=%b mem_req=%b expected 0 0", c, d_valid, mem_req);
        n_fail++;
      end
    end
    mem_ready = 1'b0;
    $display("reset_mid_access: pending store discarded");
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load_wait();
    test_store();
    test_contention();
    test_idle_ready();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
